// File: rtl/encoder83_queue.sv
// Sequential 8-to-3 encoder. One-cycle request pulses on D are collected into a
// pending set and then issued one index at a time on a valid/ready handshake.
// Optional build macro: ROUND_ROBIN_EN selects rotating priority. Without it,
// the highest pending index is issued first.
module encoder83_queue (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] D,
  input  logic       clr_ovr,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] code,
  output logic [3:0] count,
  output logic       ovr
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e     state_q;
  logic [7:0] pending_q;
  logic [2:0] code_q;
  logic       ovr_q;

  logic       load;
  logic [2:0] sel_idx;
  logic [7:0] load_mask;

`ifdef ROUND_ROBIN_EN
  logic [2:0] rr_ptr_q;

  // Rotating search rr_ptr-1 down to rr_ptr. The loop runs from lowest to highest
  // priority, so the last hit is the winner.
  always_comb begin
    sel_idx = '0;
    for (int k = 8; k >= 1; k--) begin
      if (pending_q[rr_ptr_q - 3'(k)]) sel_idx = rr_ptr_q - 3'(k);
    end
  end

  // Remember the last loaded index so that the next search starts just below it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (load) begin
      rr_ptr_q <= sel_idx;
    end
  end
`else
  // Fixed priority: the highest pending index wins (the last hit in ascending order).
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (pending_q[i]) sel_idx = 3'(i);
    end
  end
`endif

  // Load when the output slot is free or is being vacated this cycle. Only the
  // registered set takes part, so a pulse on D becomes eligible one cycle later.
  always_comb begin
    load      = ((state_q == StIdle) || ready) && (pending_q != 8'h00);
    load_mask = load ? (8'h01 << sel_idx) : 8'h00;
  end

  // Pending set: clear the loaded bit first, then merge new requests, so a
  // re-request in the load cycle stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~load_mask) | D;
    end
  end

  // Sticky overrun. Setting takes precedence over clearing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 1'b0;
    end else if ((D & pending_q & ~load_mask) != 8'h00) begin
      ovr_q <= 1'b1;
    end else if (clr_ovr) begin
      ovr_q <= 1'b0;
    end
  end

  // Output FSM. The code keeps its last value after the slot drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            state_q <= StHold;
            code_q  <= sel_idx;
          end
        end
        StHold: begin
          if (ready) begin
            if (load) begin
              code_q <= sel_idx;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Population count of the pending register; an index already in code is excluded.
  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, pending_q[i]};
    end
  end

  assign valid = (state_q == StHold);
  assign code  = code_q;
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_encoder83_queue.sv
// Bench for encoder83_queue. Each issued code is popped from an expected-code queue
// on every valid/ready handshake; the scenario tasks also check count, valid, code and ovr.
module tb_encoder83_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] D;
  logic       clr_ovr;
  logic       ready;
  logic       valid;
  logic [2:0] code;
  logic [3:0] count;
  logic       ovr;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_code;

  always #5 clk = ~clk;

  encoder83_queue dut (
    .clk     (clk),
    .reset   (reset),
    .D       (D),
    .clr_ovr (clr_ovr),
    .ready   (ready),
    .valid   (valid),
    .code    (code),
    .count   (count),
    .ovr     (ovr)
  );

  // Handshake monitor: inputs change 1ns after posedge, so the negedge values are the
  // values the next edge will see.
  always @(negedge clk) begin
    if (reset === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL handshake: got code %0d, expected no handshake", code);
      end else begin
        exp_code = exp_q.pop_front();
        if (code !== exp_code) begin
          n_fail++;
          $display("FAIL handshake: got code %0d, expected %0d", code, exp_code);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    D     = 8'hFF;
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || code !== 3'd0 || count !== 4'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_1: got v=%b c=%0d n=%0d o=%b, expected 0 0 0 0", valid, code, count, ovr);
    end
    step();
    reset = 1'b0;
    D     = 8'h00;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || code !== 3'd0 || count !== 4'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_2: got v=%b c=%0d n=%0d o=%b, expected 0 0 0 0", valid, code, count, ovr);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || code !== 3'd0 || count !== 4'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: got v=%b c=%0d n=%0d o=%b, expected 0 0 0 0", valid, code, count,
               ovr);
    end
  endtask

  task automatic test_burst();
    logic [2:0] codes[3];
    codes = '{3'd7, 3'd5, 3'd2};
    step();
    D     = 8'b1010_0100;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(codes[i]);
    step();
    D = 8'h00;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd3 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_capture: got n=%0d v=%b, expected 3 0", count, valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b1 || code !== codes[i] || count !== 4'(2 - i)) begin
        n_fail++;
        $display("FAIL burst_issue%0d: got v=%b c=%0d n=%0d, expected 1 %0d %0d", i, valid, code,
                 count, codes[i], 2 - i);
      end
    end
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL burst_drain: got v=%b n=%0d, expected 0 0", valid, count);
    end
  endtask

  task automatic test_backpressure();
    step();
    ready = 1'b0;
    D     = 8'b0000_1010;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd1);
    step();
    D = 8'h00;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd2 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_capture: got n=%0d v=%b, expected 2 0", count, valid);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b1 || code !== 3'd3 || count !== 4'd1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b c=%0d n=%0d, expected 1 3 1", i, valid, code, count);
      end
    end
    step();
    ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || code !== 3'd1 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL bp_next: got v=%b c=%0d n=%0d, expected 1 1 0", valid, code, count);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b, expected 0", valid);
    end
  endtask

  task automatic test_overrun();
    step();
    ready = 1'b0;
    D     = 8'h01;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd4);
    step();
    D = 8'h00;
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || code !== 3'd0 || count !== 4'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_hold: got v=%b c=%0d n=%0d o=%b, expected 1 0 0 0", valid, code, count, ovr);
    end
    step();
    D = 8'h10;
    step();
    D = 8'h00;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd1 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: got n=%0d o=%b, expected 1 0", count, ovr);
    end
    step();
    D = 8'h10;
    step();
    D = 8'h00;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd1 || ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_merge: got n=%0d o=%b, expected 1 1", count, ovr);
    end
    // Another merge together with a clear: the set must win.
    step();
    D       = 8'h10;
    clr_ovr = 1'b1;
    step();
    D       = 8'h00;
    clr_ovr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd1 || ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set_wins: got n=%0d o=%b, expected 1 1", count, ovr);
    end
    step();
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovr !== 1'b0 || count !== 4'd1 || valid !== 1'b1 || code !== 3'd0) begin
      n_fail++;
      $display("FAIL ovr_clear: got o=%b n=%0d v=%b c=%0d, expected 0 1 1 0", ovr, count, valid, code);
    end
    step();
    ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || code !== 3'd4 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL ovr_drain4: got v=%b c=%0d n=%0d, expected 1 4 0", valid, code, count);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain: got v=%b, expected 0", valid);
    end
  endtask

  task automatic test_rerequest();
    step();
    ready = 1'b1;
    D     = 8'h40;
    exp_q.push_back(3'd6);
    step();
    D = 8'h40;
    exp_q.push_back(3'd6);
    step();
    D = 8'h00;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || code !== 3'd6 || count !== 4'd1 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL rereq_load: got v=%b c=%0d n=%0d o=%b, expected 1 6 1 0", valid, code, count, ovr);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || code !== 3'd6 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL rereq_again: got v=%b c=%0d n=%0d, expected 1 6 0", valid, code, count);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rereq_drain: got v=%b, expected 0", valid);
    end
  endtask

  task automatic test_reset_midflight();
    step();
    ready = 1'b0;
    D     = 8'h21;
    step();
    D = 8'h00;
    step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || code !== 3'd5 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_hold: got v=%b c=%0d n=%0d, expected 1 5 1", valid, code, count);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || code !== 3'd0 || count !== 4'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b c=%0d n=%0d o=%b, expected 0 0 0 0", valid, code, count, ovr);
    end
  endtask

  task automatic test_priority_order();
    step();
    ready = 1'b1;
    D     = 8'h82;
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd7);
`else
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd1);
`endif
    step();
    D = 8'h80;
    step();
    D = 8'h00;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || code !== 3'd7 || count !== 4'd2) begin
      n_fail++;
      $display("FAIL prio_first: got v=%b c=%0d n=%0d, expected 1 7 2", valid, code, count);
    end
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL prio_drain: got v=%b n=%0d, expected 0 0", valid, count);
    end
  endtask

  task automatic test_full();
    step();
    reset = 1'b1;
    ready = 1'b0;
    step();
    reset = 1'b0;
    D     = 8'hFF;
    for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
    step();
    D = 8'h00;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd8 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_count: got n=%0d v=%b, expected 8 0", count, valid);
    end
    step();
    ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL full_drain: got v=%b n=%0d, expected 0 0", valid, count);
    end
  endtask

  initial begin
    reset   = 1'b1;
    D       = 8'h00;
    clr_ovr = 1'b0;
    ready   = 1'b0;
    test_reset();
    test_burst();
    test_backpressure();
    test_overrun();
    test_rerequest();
    test_reset_midflight();
    test_priority_order();
    test_full();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d codes never issued, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
